// File: rtl/instr_loader.sv
// instr_loader: packs UART RX bytes big-endian into SIZE-bit words and writes them to instruction memory.
// Optional partial-word watchdog is compiled in when LOADER_TIMEOUT_EN is defined.
module instr_loader #(
  parameter int              SIZE            = 32,
  parameter int              MAX_INSTRUCTION = 64,
  parameter int              ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter logic [SIZE-1:0] HALT_WORD       = 32'hFFFF_FFFF,
  parameter int              TIMEOUT_CYCLES  = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_start,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [SIZE-1:0]       o_mem_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [1:0]            o_state,
  output logic [4:0]            o_byte_counter,
  output logic [4:0]            o_instruction_counter
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [SIZE-1:0]       data;
  } wr_req_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_INSTRUCTION - 1);

  state_e                state_q, state_d;
  logic [SIZE-1:0]       word_q, word_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]            icnt_q, icnt_d;
  wr_req_t               wr_q, wr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last_word;

`ifdef LOADER_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // wr_q holds the word being written this cycle and, afterwards, the last written address.
  assign last_word = (wr_q.data == HALT_WORD) || (wr_q.addr == LAST_ADDR);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    icnt_d  = icnt_q;
    wr_d    = wr_q;
    wr_d.we = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    tmo_d   = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = RECV;
          word_d  = '0;
          bcnt_d  = '0;
          addr_d  = '0;
          icnt_d  = '0;
          wr_d.addr = '0;
        end
      end
      RECV: begin
        if (i_rx_done) begin
          word_d = {word_q[SIZE-9:0], i_rx_data};
          if (bcnt_q == 2'd3) begin
            bcnt_d    = '0;
            state_d   = WRITE;
            wr_d.we   = 1'b1;
            wr_d.addr = addr_q;
            wr_d.data = {word_q[SIZE-9:0], i_rx_data};
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (bcnt_q != 2'd0) begin
          if (tmo_q == TMO_LAST) begin
            word_d = '0;
            bcnt_d = '0;
            err_d  = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
`endif
      end
      WRITE: begin
        icnt_d = (icnt_q == 5'd31) ? icnt_q : icnt_q + 5'd1;
        if (last_word) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          // A byte landing in the write cycle starts the next word.
          if (i_rx_done) begin
            word_d = {{(SIZE-8){1'b0}}, i_rx_data};
            bcnt_d = 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RECV) || (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
      icnt_q  <= '0;
      wr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      addr_q  <= addr_d;
      icnt_q  <= icnt_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_mem_we              = wr_q.we;
  assign o_mem_addr            = wr_q.addr;
  assign o_mem_data            = wr_q.data;
  assign o_busy                = busy_q;
  assign o_done                = done_q;
  assign o_state               = state_q;
  assign o_byte_counter        = {3'b000, bcnt_q};
  assign o_instruction_counter = icnt_q;

`ifdef LOADER_TIMEOUT_EN
  assign o_error = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign o_error = 1'b0;
`endif

endmodule

// File: doc/instr_loader.md
# instr_loader

Receives program bytes from the debug UART receiver and packs each group of four into a 32-bit instruction word. Each finished word is written to the MIPS instruction memory at consecutive addresses. The block sits between the UART RX stage and the instruction memory write port of the `mips` core. It finishes a load on a halt word or on a full memory, and exposes byte and instruction counters for on-board debug.

## Interface
- `SIZE`, 32, instruction word width in bits; must equal 4×8.
- `MAX_INSTRUCTION`, 64, instruction memory depth in words.
- `ADDR_WIDTH`, `$clog2(MAX_INSTRUCTION)`, word address width.
- `HALT_WORD`, 32'hFFFF_FFFF, word that terminates a load.
- `TIMEOUT_CYCLES`, 100000, idle-cycle limit inside a partial word; used only with `LOADER_TIMEOUT_EN`.

Ports:
- `i_clk` in 1: system clock, the wizard output clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_rx_data` in 8: byte from UART RX; valid only while `i_rx_done` is high.
- `i_rx_done` in 1: one-cycle tick, a byte is available.
- `i_start` in 1: begin a load; sampled in IDLE and DONE.
- `o_mem_we` in/out: out 1: instruction memory write enable, one-cycle pulse.
- `o_mem_addr` out `ADDR_WIDTH`: write word address.
- `o_mem_data` out `SIZE`: write data.
- `o_busy` out 1: high in RECV and WRITE.
- `o_done` out 1: level, high in DONE.
- `o_error` out 1: one-cycle pulse on timeout; constant 0 without the macro.
- `o_state` out 2: encoded state, IDLE=0, RECV=1, WRITE=2, DONE=3.
- `o_byte_counter` out 5: bytes held in the current partial word, 0..3.
- `o_instruction_counter` out 5: words written since the last start, saturates at 31 for display.

## Operation
- Reset sets every output and register to 0: state IDLE, shift register 0, address counter 0.
- IDLE:
  - `i_start` clears the counters and the shift register, then moves to RECV.
  - `i_rx_done` is ignored.
- RECV:
  - On `i_rx_done`, the word becomes `{word[23:0], i_rx_data}`. The first byte ends up in [31:24] (big-endian).
  - `byte_counter` increments on each byte.
  - On the 4th byte, `byte_counter` returns to 0 and the state moves to WRITE.
- WRITE, exactly one cycle:
  - `o_mem_we`=1, `o_mem_addr` = word address, `o_mem_data` = assembled word.
  - The word address then increments.
  - If the word equals `HALT_WORD`, or the address written was `MAX_INSTRUCTION-1`, go to DONE. Otherwise go to RECV.
  - The halt word itself is written to memory.
- Byte arriving during WRITE:
  - If the next state is RECV, the byte is accepted as byte 0 of the next word (`byte_counter`=1). No byte is lost.
  - If the next state is DONE, the byte is dropped.
- DONE:
  - `o_done`=1, and `o_mem_addr` holds the last written address.
  - `i_start` restarts exactly as from IDLE.
- `i_start` is ignored in RECV and WRITE.
- `o_instruction_counter` = min(words written, 31).
- Reset in any state, including mid-word or in WRITE, returns to IDLE with counters cleared and no write issued on that cycle.

## Timing
- `o_mem_we` rises in the cycle after the clock edge that captured the 4th byte. Latency is 1 cycle from the 4th `i_rx_done` to the write.
- All outputs are registered. `o_busy` rises 1 cycle after `i_start` is sampled.
- Back-to-back `i_rx_done` on consecutive cycles is supported. The maximum throughput is 1 byte per cycle; the 5th consecutive byte falls in WRITE and is handled as above.
- `o_done` rises 1 cycle after the final WRITE.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - In RECV with `byte_counter`≠0, a counter counts cycles without `i_rx_done`.
  - On reaching `TIMEOUT_CYCLES`: the partial word is discarded, `byte_counter`=0, `o_error` pulses for 1 cycle, and the state stays RECV.
  - The counter clears on every byte and whenever `byte_counter`=0.
- `LOADER_TIMEOUT_EN` undefined: no timeout logic, `o_error` is tied to 0, and a partial word waits indefinitely.

## Test plan
- Reset, then `i_start`, then bytes 8'h20,8'h01,8'h00,8'h05 → one write: addr 0, data 32'h2001_0005. `o_instruction_counter`=1, state RECV.
- Load 3 words followed by FF,FF,FF,FF → 4 writes at addr 0..3, the last with data 32'hFFFF_FFFF. `o_done`=1, `o_instruction_counter`=4.
- With `MAX_INSTRUCTION`=4, send 5 non-halt words → writes at addr 0..3 only, DONE after the 4th write. The 5th word produces no `o_mem_we`.
- Eight bytes on consecutive cycles (`i_rx_done` held high) → two writes with the correct words. The 5th byte is present in the second word's bits [31:24].
- Assert `i_rst` after 2 bytes → state 0, `o_byte_counter`=0, no write. A new `i_start` plus 4 bytes writes to addr 0.
- With `LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10: send 2 bytes, then idle 10 cycles → `o_error` pulses once and `o_byte_counter`=0. The next 4 bytes form a correct word.
